noc_route_arbiter: RTL and testbench
====================================

// Module: noc_route_arbiter
// PURPOSE
// - Clocked 5-port switch allocator for one node of the 5x3 NoC mesh (15 nodes, 57-bit packets).
// - Per input: computes the XY route from the packet hop fields and decrements the consumed hop.
// - Per output: round-robin arbitration between contending inputs, then a registered output stage.
// - Sits between the node's input links and its output links / local PE port.
// PARAMETERS
// - WIDTH_packet  57  packet width; layout fixed in noc_pkg
// - NPORT          5  port count; index 0=PE 1=N 2=S 3=E 4=W
// PORTS
// - clk        in   1              single clock; all state on rising edge
// - rst        in   1              synchronous, active-high reset
// - in_valid   in   NPORT          per-input packet valid
// - in_data    in   NPORT*57       input packets; port p at [p*57 +: 57]
// - in_ready   out  NPORT          per-input accept (combinational)
// - out_valid  out  NPORT          per-output packet valid (registered)
// - out_data   out  NPORT*57       output packets (registered)
// - out_ready  in   NPORT          downstream accept
// - err_uturn  out  1              sticky: a packet routed back to its arrival port
// BEHAVIOUR
// - Packet fields: [55:52] src, [51:48] dest, [47] xdir (1=E), [46:44] xhop,
//   [43] ydir (1=N), [42:40] yhop, [39:0] payload. Bit 56 passes through unchanged.
// - Route, in priority order:
//   - xhop!=0: E if xdir else W; decrement xhop.
//   - else yhop!=0: N if ydir else S; decrement yhop.
//   - else PE; no field changes.
//   - Decrement is 3-bit, never applied to 0. All other bits are copied unchanged.
// - Handshake is valid/ready on both sides.
//   - Sender holds in_valid and in_data stable until in_valid&in_ready in a cycle.
//   - Output transfer: out_valid&out_ready.
// - Output register o is free when !out_valid[o] | out_ready[o] (drain and refill in the same cycle).
// - Arbitration for output o:
//   - Requesters are the inputs with in_valid whose route==o.
//   - Grant the first requester found searching from ptr[o] upward, modulo NPORT.
//   - Grant is issued only when register o is free.
//   - in_ready[p]=1 iff p is granted. At most one grant per output; each input requests one output.
// - Transfer on grant:
//   - Next edge: out_data[o] <= modified packet, out_valid[o] <= 1, ptr[o] <= grant+1 (wraps 4->0).
//   - Latency: 1 cycle input-accept to out_valid. Full throughput of 1 packet/cycle/output.
// - No grant: ptr[o] is held. out_valid[o] clears on out_ready with no new grant.
// - Losing requesters keep in_ready=0 and retry next cycle with no loss or reorder.
// - U-turn: route==arrival port for p in 1..4, or PE->PE for p=0.
//   - Packet is still forwarded.
//   - err_uturn <= 1 on the accept cycle and stays set until rst.
// - Reset (also mid-operation):
//   - out_valid=0, out_data=0, all ptr=0, err_uturn=0.
//   - in_ready forced to 0 while rst=1.
//   - Buffered packets are discarded.
// - Independent outputs never block each other. Head-of-line blocking exists per input only.
// STRUCTURE
// - noc_pkg:
//   - field bit-position localparams
//   - port index enum (PE,N,S,E,W)
//   - typedef packed struct noc_pkt_t (57 b)
//   - function route_f(pkt) -> {port, next_pkt}
// - Sub-module rr_arb5: req[4:0], ptr[2:0], en -> gnt one-hot, gnt_idx.
//   - Instantiated once per output.
// - Top-level holds: route compute per input, request matrix, output registers, pointer registers, err flag.
// TESTING
// - Route: W input, xdir=1, xhop=2, yhop=1 -> out E; xhop=1, yhop=1; payload unchanged; out_valid 1 cycle after accept.
// - Local delivery: N input, xhop=0, yhop=0 -> out PE; packet bit-identical.
// - Contention: PE, N, S all target E every cycle, out_ready=1, ptr=0 -> grant order PE,N,S,PE,N,S; one packet per cycle.
// - Backpressure: out_ready[E]=0 for 5 cycles with a packet held -> no new grant to E, winner's in_ready=0, ptr held;
//   release -> drain and refill in the same cycle.
// - Parallelism: E->W and W->E simultaneously -> both accepted the same cycle, no stall.
// - U-turn/reset: E input, xdir=1, xhop=1 -> err_uturn=1 and sticky.
//   - rst asserted with out_valid=1 -> next cycle all outputs 0, err_uturn=0, in_ready=0 during rst.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the 5x3 mesh node: packet layout, port indices and the XY route function.
package noc_pkg;

  localparam int unsigned PktWidth = 57;
  localparam int unsigned NumPorts = 5;

  localparam int unsigned XDIR_BIT = 47;
  localparam int unsigned XHOP_MSB = 46;
  localparam int unsigned XHOP_LSB = 44;
  localparam int unsigned YDIR_BIT = 43;
  localparam int unsigned YHOP_MSB = 42;
  localparam int unsigned YHOP_LSB = 40;

  typedef enum logic [2:0] {
    PortPe = 3'd0,
    PortN  = 3'd1,
    PortS  = 3'd2,
    PortE  = 3'd3,
    PortW  = 3'd4
  } port_e;

  typedef struct packed {
    logic        rsvd;
    logic [3:0]  src;
    logic [3:0]  dest;
    logic        xdir;
    logic [2:0]  xhop;
    logic        ydir;
    logic [2:0]  yhop;
    logic [39:0] payload;
  } noc_pkt_t;

  typedef struct packed {
    port_e    port;
    noc_pkt_t pkt;
  } route_t;

  // X is fully consumed before Y; only the hop field being consumed is touched.
  function automatic route_t route_f(input noc_pkt_t pkt);
    logic [PktWidth-1:0] raw;
    route_t              r;
    raw    = pkt;
    r.port = PortPe;
    if (raw[XHOP_MSB:XHOP_LSB] != 3'd0) begin
      r.port                 = raw[XDIR_BIT] ? PortE : PortW;
      raw[XHOP_MSB:XHOP_LSB] = raw[XHOP_MSB:XHOP_LSB] - 3'd1;
    end else if (raw[YHOP_MSB:YHOP_LSB] != 3'd0) begin
      r.port                 = raw[YDIR_BIT] ? PortN : PortS;
      raw[YHOP_MSB:YHOP_LSB] = raw[YHOP_MSB:YHOP_LSB] - 3'd1;
    end
    r.pkt = noc_pkt_t'(raw);
    return r;
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Five-way round-robin arbiter: first requester at or above i_ptr (mod 5) wins when enabled.
module rr_arb5 (
  input  logic [4:0] i_req,
  input  logic [2:0] i_ptr,
  input  logic       i_en,
  output logic [4:0] o_gnt,
  output logic [2:0] o_gnt_idx
);

  logic [2:0] w_ptr;
  logic [4:0] w_rot;
  logic [2:0] w_off;
  logic [2:0] w_idx;

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Out-of-range pointers cannot occur, but fall back to 0 rather than alias.
  assign w_ptr = (i_ptr > 3'd4) ? 3'd0 : i_ptr;

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < 5; k++) begin
      w_rot[k] = i_req[wrap5({1'b0, w_ptr} + 4'(k))];
    end
    w_off = '0;
    for (int k = 4; k >= 0; k--) begin
      if (w_rot[k]) w_off = 3'(k);
    end
  end

  assign w_idx     = wrap5({1'b0, w_ptr} + {1'b0, w_off});
  assign o_gnt_idx = w_idx;
  assign o_gnt     = (i_en && (|i_req)) ? (5'b00001 << w_idx) : 5'b00000;

endmodule

// File: rtl/noc_route_arbiter.sv
// Per-node switch allocator: XY route per input, round-robin grant per output, registered outputs.
module noc_route_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH_packet = PktWidth,
  parameter int unsigned NPORT        = NumPorts
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORT-1:0]          in_valid,
  input  logic [NPORT*WIDTH_packet-1:0] in_data,
  output logic [NPORT-1:0]          in_ready,
  output logic [NPORT-1:0]          out_valid,
  output logic [NPORT*WIDTH_packet-1:0] out_data,
  input  logic [NPORT-1:0]          out_ready,
  output logic                      err_uturn
);

  port_e            w_route_port [NPORT];
  noc_pkt_t         w_route_pkt  [NPORT];
  logic [NPORT-1:0] w_req        [NPORT];
  logic [NPORT-1:0] w_gnt        [NPORT];
  logic [2:0]       w_gnt_idx    [NPORT];
  noc_pkt_t         w_sel_pkt    [NPORT];
  logic [NPORT-1:0] w_free;
  logic             w_uturn;

  logic [NPORT-1:0] r_out_valid;
  noc_pkt_t         r_out_data [NPORT];
  logic [2:0]       r_ptr      [NPORT];
  logic             r_err_uturn;

  for (genvar p = 0; p < NPORT; p++) begin : g_route
    route_t w_r;
    assign w_r             = route_f(noc_pkt_t'(in_data[p*WIDTH_packet +: WIDTH_packet]));
    assign w_route_port[p] = w_r.port;
    assign w_route_pkt[p]  = w_r.pkt;
  end

  // w_req[o][p]: input p wants output o this cycle.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      w_req[o] = '0;
      for (int p = 0; p < NPORT; p++) begin
        w_req[o][p] = in_valid[p] && (w_route_port[p] == 3'(o));
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    assign w_free[o] = !r_out_valid[o] || out_ready[o];

    rr_arb5 u_rr_arb5 (
      .i_req     (w_req[o]),
      .i_ptr     (r_ptr[o]),
      .i_en      (w_free[o] && !rst),
      .o_gnt     (w_gnt[o]),
      .o_gnt_idx (w_gnt_idx[o])
    );

    assign out_data[o*WIDTH_packet +: WIDTH_packet] = r_out_data[o];
  end

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NPORT; o++) begin
      w_sel_pkt[o] = '0;
      for (int p = 0; p < NPORT; p++) begin
        in_ready[p] = in_ready[p] | w_gnt[o][p];
        if (w_gnt[o][p]) w_sel_pkt[o] = w_route_pkt[p];
      end
    end
  end

  // Port 0 routed to PE is also a U-turn, so one comparison covers every input.
  always_comb begin
    w_uturn = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (in_ready[p] && (w_route_port[p] == 3'(p))) w_uturn = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_err_uturn <= 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        r_out_data[o] <= '0;
        r_ptr[o]      <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (|w_gnt[o]) begin
          r_out_valid[o] <= 1'b1;
          r_out_data[o]  <= w_sel_pkt[o];
          r_ptr[o]       <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
        end else if (out_ready[o]) begin
          r_out_valid[o] <= 1'b0;
        end
      end
      if (w_uturn) r_err_uturn <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign err_uturn = r_err_uturn;

endmodule

// File: tb/tb_noc_route_arbiter.sv
// Directed bench for noc_route_arbiter: expected packets queued per output, checked by a monitor.
module tb_noc_route_arbiter;

  localparam int W = 57;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready;
  logic           err_uturn;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] q [N][$];
  logic [W-1:0] mon_exp;

  noc_route_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err_uturn (err_uturn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic b56, input logic [3:0] src,
                                      input logic [3:0] dest, input logic xd,
                                      input logic [2:0] xh, input logic yd,
                                      input logic [2:0] yh, input logic [39:0] pl);
    return {b56, src, dest, xd, xh, yd, yh, pl};
  endfunction

  task automatic put(input int p, input logic [W-1:0] x);
    in_data[p*W +: W] = x;
  endtask

  // One cycle: check in_ready mid-cycle, then advance to just after the next edge.
  task automatic cyc(input logic [N-1:0] exp_rdy, input string name);
    @(negedge clk);
    chk(name, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < N; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          if (q[o].size() == 0) begin
            chk($sformatf("unexpected_out%0d", o), 64'(out_data[o*W +: W]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_exp = q[o].pop_front();
            chk($sformatf("out_data%0d", o), 64'(out_data[o*W +: W]), 64'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] pk [3][2];
    logic [2:0]   ncons [3];
    logic [N-1:0] cont_rdy [6];
    logic [W-1:0] ut_exp;

    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;

    // Reset: in_ready held low even with a valid request.
    @(posedge clk); #1;
    in_valid = 5'b00001;
    put(0, mk(0, 4'h0, 4'h1, 1, 3'd1, 0, 3'd0, 40'h1));
    cyc(5'b00000, "rst_in_ready");
    in_valid = '0;
    rst      = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data_lo", out_data[63:0], 64'd0);
    chk("rst_err", 64'(err_uturn), 64'd0);

    // Route: W input, east two hops then north one.
    in_valid = 5'b10000;
    put(4, mk(1, 4'h3, 4'h9, 1, 3'd2, 1, 3'd1, 40'h00DEADBEEF));
    q[3].push_back(mk(1, 4'h3, 4'h9, 1, 3'd1, 1, 3'd1, 40'h00DEADBEEF));
    cyc(5'b10000, "route_rdy");
    chk("route_latency", 64'(out_valid), 64'(5'b01000));
    in_valid = '0;
    cyc(5'b00000, "route_idle");
    chk("route_clear", 64'(out_valid), 64'd0);

    // Local delivery: N input with no hops left.
    in_valid = 5'b00010;
    put(1, mk(0, 4'h7, 4'h4, 0, 3'd0, 1, 3'd0, 40'h123456789A));
    q[0].push_back(mk(0, 4'h7, 4'h4, 0, 3'd0, 1, 3'd0, 40'h123456789A));
    cyc(5'b00010, "local_rdy");
    in_valid = '0;
    cyc(5'b00000, "local_idle");

    // Contention: PE, N, S all to E; pointer starts at 0.
    for (int p = 0; p < 3; p++) begin
      ncons[p] = 3'd0;
      for (int k = 0; k < 2; k++) begin
        pk[p][k] = mk(0, 4'(p), 4'(k), 1, 3'd3, 0, 3'd0, {32'hC000_0000, 4'(p), 4'(k)});
      end
    end
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) begin
        q[3].push_back(mk(0, 4'(p), 4'(k), 1, 3'd2, 0, 3'd0, {32'hC000_0000, 4'(p), 4'(k)}));
      end
    end
    cont_rdy[0] = 5'b00001; cont_rdy[1] = 5'b00010; cont_rdy[2] = 5'b00100;
    cont_rdy[3] = 5'b00001; cont_rdy[4] = 5'b00010; cont_rdy[5] = 5'b00100;
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 3; p++) begin
        in_valid[p] = (ncons[p] < 3'd2);
        if (ncons[p] < 3'd2) put(p, pk[p][ncons[p][0]]);
      end
      cyc(cont_rdy[c], $sformatf("contend_rdy%0d", c));
      for (int p = 0; p < 3; p++) begin
        if (cont_rdy[c][p]) ncons[p] = ncons[p] + 3'd1;
      end
    end
    in_valid = '0;
    cyc(5'b00000, "contend_idle");

    // Backpressure on E: fill, stall five cycles, then drain and refill together.
    out_ready = 5'b10111;
    in_valid  = 5'b00010;
    put(1, mk(0, 4'h1, 4'h3, 1, 3'd1, 0, 3'd2, 40'hA0A0A0A0A0));
    q[3].push_back(mk(0, 4'h1, 4'h3, 1, 3'd0, 0, 3'd2, 40'hA0A0A0A0A0));
    cyc(5'b00010, "bp_fill");
    in_valid = 5'b00101;
    put(2, mk(0, 4'h2, 4'h3, 1, 3'd5, 1, 3'd0, 40'hB0B0B0B0B0));
    put(0, mk(1, 4'h0, 4'h3, 1, 3'd7, 0, 3'd0, 40'hC0C0C0C0C0));
    q[3].push_back(mk(0, 4'h2, 4'h3, 1, 3'd4, 1, 3'd0, 40'hB0B0B0B0B0));
    q[3].push_back(mk(1, 4'h0, 4'h3, 1, 3'd6, 0, 3'd0, 40'hC0C0C0C0C0));
    for (int c = 0; c < 5; c++) cyc(5'b00000, $sformatf("bp_hold%0d", c));
    chk("bp_held_valid", 64'(out_valid[3]), 64'd1);
    out_ready = '1;
    cyc(5'b00100, "bp_release");
    in_valid = 5'b00001;
    cyc(5'b00001, "bp_next");
    in_valid = '0;
    cyc(5'b00000, "bp_idle");

    // Parallel: E->W, W->E and PE->S in the same cycle.
    in_valid = 5'b11001;
    put(3, mk(0, 4'h3, 4'h4, 0, 3'd1, 0, 3'd1, 40'h3333333333));
    put(4, mk(0, 4'h4, 4'h3, 1, 3'd1, 1, 3'd3, 40'h4444444444));
    put(0, mk(0, 4'h0, 4'h2, 0, 3'd0, 0, 3'd2, 40'h5555555555));
    q[4].push_back(mk(0, 4'h3, 4'h4, 0, 3'd0, 0, 3'd1, 40'h3333333333));
    q[3].push_back(mk(0, 4'h4, 4'h3, 1, 3'd0, 1, 3'd3, 40'h4444444444));
    q[2].push_back(mk(0, 4'h0, 4'h2, 0, 3'd0, 0, 3'd1, 40'h5555555555));
    cyc(5'b11001, "par_rdy");
    chk("par_valid", 64'(out_valid), 64'(5'b11100));
    in_valid = '0;
    cyc(5'b00000, "par_idle");

    // U-turn: E input routed east; held in the register for the reset test.
    chk("ut_err_before", 64'(err_uturn), 64'd0);
    out_ready = '0;
    in_valid  = 5'b01000;
    put(3, mk(0, 4'h3, 4'h3, 1, 3'd1, 0, 3'd2, 40'h0F0F0F0F0F));
    ut_exp = mk(0, 4'h3, 4'h3, 1, 3'd0, 0, 3'd2, 40'h0F0F0F0F0F);
    cyc(5'b01000, "ut_rdy");
    chk("ut_err_set", 64'(err_uturn), 64'd1);
    chk("ut_fwd_valid", 64'(out_valid), 64'(5'b01000));
    chk("ut_fwd_data", 64'(out_data[3*W +: W]), 64'(ut_exp));
    in_valid = '0;
    cyc(5'b00000, "ut_idle0");
    cyc(5'b00000, "ut_idle1");
    chk("ut_sticky", 64'(err_uturn), 64'd1);

    // Mid-operation reset with a packet held on E.
    rst      = 1'b1;
    in_valid = 5'b00001;
    put(0, mk(0, 4'h0, 4'h3, 1, 3'd1, 0, 3'd0, 40'h7));
    cyc(5'b00000, "rst2_in_ready");
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_data_e", 64'(out_data[3*W +: W]), 64'd0);
    chk("rst2_err", 64'(err_uturn), 64'd0);
    for (int o = 0; o < N; o++) q[o].delete();
    rst       = 1'b0;
    out_ready = '1;

    // Pointer for E must be back at 0: PE beats W.
    in_valid = 5'b10001;
    put(0, mk(0, 4'h0, 4'h3, 1, 3'd2, 0, 3'd0, 40'h0000000A0A));
    put(4, mk(0, 4'h4, 4'h3, 1, 3'd4, 0, 3'd0, 40'h0000000B0B));
    q[3].push_back(mk(0, 4'h0, 4'h3, 1, 3'd1, 0, 3'd0, 40'h0000000A0A));
    q[3].push_back(mk(0, 4'h4, 4'h3, 1, 3'd3, 0, 3'd0, 40'h0000000B0B));
    cyc(5'b00001, "ptr_rst0");
    in_valid = 5'b10000;
    cyc(5'b10000, "ptr_rst1");
    in_valid = '0;
    cyc(5'b00000, "end_idle0");
    cyc(5'b00000, "end_idle1");

    for (int o = 0; o < N; o++) begin
      chk($sformatf("q_empty%0d", o), 64'(q[o].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
